delay_line: RTL

- Parametrised successor to the single-bit fixed-depth shift register.
- Multi-bit data path, runtime-selectable delay up to a maximum depth, shift enable (stall) and synchronous flush.
- Per-stage valid tracking, plus a fill counter that reports when the selected delay has been fully primed.
- Used wherever a stream must be aligned by a programmable number of cycles against a parallel path.

---
 rtl/delay_line.sv | 117 +++++++++++
 1 files changed

// File: rtl/delay_line.sv
// Programmable-tap delay line: a max_depth-stage {valid, data} shift chain with
// stall, synchronous flush, runtime tap select and a fill counter for "primed".

module delay_stage #(
    parameter int width = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             flush,
    input  logic             valid_d,
    input  logic [width-1:0] data_d,
    output logic             valid_q,
    output logic [width-1:0] data_q
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (enable) begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

module delay_line #(
    parameter int width      = 8,
    parameter int max_depth  = 16,
    parameter int delay_bits = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [delay_bits-1:0] delay,
    input  logic [width-1:0]      data_in,
    input  logic                  valid_in,
    output logic [width-1:0]      data_out,
    output logic                  valid_out,
    output logic                  primed
);

    localparam int                    cnt_w     = $clog2(max_depth + 1);
    localparam logic [delay_bits-1:0] depth_sel = delay_bits'(max_depth);
    localparam logic [cnt_w-1:0]      depth_cnt = cnt_w'(max_depth);

    logic [max_depth-1:0][width-1:0] stage_data;
    logic [max_depth-1:0]            vld_pipe;
    logic [cnt_w-1:0]                fill_count;
    logic [delay_bits-1:0]           d_eff;
    logic [delay_bits-1:0]           tap;

    genvar i;
    generate
        for (i = 0; i < max_depth; i++) begin : g_stage
            logic [width-1:0] data_d;
            logic             valid_d;
            if (i == 0) begin : g_head
                assign data_d  = data_in;
                assign valid_d = valid_in;
            end else begin : g_body
                assign data_d  = stage_data[i-1];
                assign valid_d = vld_pipe[i-1];
            end
            delay_stage #(.width(width)) u_stage (
                .clock   (clock),
                .reset_n (reset_n),
                .enable  (enable),
                .flush   (flush),
                .valid_d (valid_d),
                .data_d  (data_d),
                .valid_q (vld_pipe[i]),
                .data_q  (stage_data[i])
            );
        end
    endgenerate

    // Clamp the requested delay into 1..max_depth; a zero request means one edge.
    always_comb begin
        d_eff = delay;
        if (delay == '0)
            d_eff = delay_bits'(1);
        else if (delay > depth_sel)
            d_eff = depth_sel;
        tap = d_eff - delay_bits'(1);
    end

    always_comb begin
        data_out  = '0;
        valid_out = 1'b0;
        for (int k = 0; k < max_depth; k++) begin
            if (tap == delay_bits'(k)) begin
                data_out  = stage_data[k];
                valid_out = vld_pipe[k];
            end
        end
    end

    // Counts enabled edges since reset/flush, saturating at the chain length.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            fill_count <= '0;
        else if (flush)
            fill_count <= '0;
        else if (enable && fill_count != depth_cnt)
            fill_count <= fill_count + cnt_w'(1);
    end

    assign primed = 32'(fill_count) >= 32'(d_eff);

endmodule
